vend_datapath: RTL and testbench
================================

VEND_DATAPATH -- requirements
Module: vend_datapath

Interface
REQ-001 SHALL have parameter CREDIT_W, default 8: width of credit and change registers, in 5-cent units.
REQ-002 SHALL have parameter MAX_CREDIT, default 40: credit ceiling in units (200c).
REQ-003 SHALL have parameter IDLE_CYC, default 16: cycles `in` stays high after the last accepted coin.
REQ-004 SHALL provide ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle coin-inserted strobe.
- coin_type  in  2  0=5c(1u), 1=10c(2u), 2=25c(5u), 3=invalid.
- sel  in  2  product select; held stable from check to done.
- start, ldM, check, RC, canceled, done  in  1  controller state decodes.
- in  out  1  coin-activity indicator to controller.
- error  out  1  insufficient credit, to controller.
- coin_reject  out  1  one-cycle pulse, coin returned.
- vend  out  1  one-cycle product-release pulse.
- coin_out_valid  out  1  change/refund coin offered.
- coin_out_type  out  2  coin offered, same encoding as coin_type.
- coin_out_ready  in  1  hopper accepts the offered coin.
- credit  out  CREDIT_W  current credit.
- pay_done  out  1  level; change/refund fully paid.
- sales_total  out  16  audit total in units.

Function
REQ-005 SHALL accept coins only while start or ldM is high; coin_valid in other states SHALL pulse coin_reject the next cycle.
REQ-006 SHALL add the coin value to credit on the edge after coin_valid; type 3 or a sum > MAX_CREDIT SHALL leave credit unchanged and pulse coin_reject.
REQ-007 SHALL reload an idle counter with IDLE_CYC on each accepted coin; in = (counter != 0); counter decrements to 0 and never wraps.
REQ-008 SHALL drive error combinationally as check & (credit < price[sel]).
REQ-009 on the first RC cycle SHALL pulse vend for exactly one cycle and load change = credit - price[sel].
REQ-010 on the first canceled cycle SHALL load change = credit with no vend.
REQ-011 SHALL clear credit to 0 in the cycle after change is loaded.
REQ-012 Dispenser FSM SHALL implement IDLE -> LOAD (on RC/canceled) -> PAY -> FIN; FIN is held until reset.
REQ-013 In PAY SHALL offer the largest coin <= remaining change (25c, then 10c, then 5c), holding coin_out_valid and coin_out_type stable until coin_out_ready.
REQ-014 On a valid&ready handshake SHALL subtract the coin value; at remaining change 0 it SHALL go to FIN.
REQ-015 Zero change SHALL go LOAD -> FIN with no coin offered.
REQ-016 pay_done SHALL be high only in FIN.
REQ-017 A coin_valid coincident with check, RC or canceled SHALL be rejected.

Reset
REQ-018 Reset low SHALL asynchronously force credit=0, change=0, idle counter=0, FSM=IDLE, sales_total=0, and every output low.
REQ-019 Reset mid-payment SHALL abandon the remaining change with no further coin_out_valid.

Configuration
REQ-020 With VEND_AUDIT_EN defined, sales_total SHALL add price[sel] on each vend pulse and saturate at 16'hFFFF.
REQ-021 With VEND_AUDIT_EN undefined, sales_total SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-022 Package vend_pkg SHALL hold the coin encodings, coin unit values and the price table (sel 0..3 = 3, 5, 7, 10 units).
REQ-023 The dispenser FSM SHALL be sub-module change_dispenser, instantiated once.

Verification
REQ-024 In ldM, insert 25c, 10c, 10c -> credit 9; in high until IDLE_CYC cycles after the last coin.
REQ-025 credit 9, sel=2, check -> error=0; RC -> one vend pulse; coin_out 25c is not offered, 10c is offered -> pay_done.
REQ-026 credit 4, sel=3, check -> error=1; canceled -> refund 10c then 10c, no vend.
REQ-027 credit 38, insert 25c -> coin_reject pulse, credit stays 38; coin_type=3 -> rejected.
REQ-028 Hold coin_out_ready low 5 cycles during PAY -> coin_out_valid and coin_out_type stable; assert reset -> all outputs 0 at once.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending datapath types: coin encodings, coin unit values, price table
// and dispenser FSM states. All money quantities are in 5-cent units.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_5C  = 2'd0,
    COIN_10C = 2'd1,
    COIN_25C = 2'd2,
    COIN_BAD = 2'd3
  } coin_t;

  localparam logic [2:0] UNITS_5C  = 3'd1;
  localparam logic [2:0] UNITS_10C = 3'd2;
  localparam logic [2:0] UNITS_25C = 3'd5;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_LOAD = 2'd1,
    D_PAY  = 2'd2,
    D_FIN  = 2'd3
  } disp_state_t;

  // Unit value of an inserted coin; the invalid code is worth nothing.
  function automatic logic [2:0] coin_units(input logic [1:0] t);
    logic [2:0] u;
    case (t)
      COIN_5C:  u = UNITS_5C;
      COIN_10C: u = UNITS_10C;
      COIN_25C: u = UNITS_25C;
      default:  u = 3'd0;
    endcase
    return u;
  endfunction

  function automatic logic [3:0] price_units(input logic [1:0] s);
    logic [3:0] p;
    case (s)
      2'd0:    p = 4'd3;
      2'd1:    p = 4'd5;
      2'd2:    p = 4'd7;
      default: p = 4'd10;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_datapath_if.sv
// Controller/coin-mech/hopper signal bundle for the vending datapath; master is
// the controller side, slave is the datapath.
interface vend_datapath_if #(
  parameter int CREDIT_W = 8
);
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic [1:0]          sel;
  logic                start;
  logic                ldM;
  logic                check;
  logic                RC;
  logic                canceled;
  logic                done;
  logic                in;
  logic                error;
  logic                coin_reject;
  logic                vend;
  logic                coin_out_valid;
  logic [1:0]          coin_out_type;
  logic                coin_out_ready;
  logic [CREDIT_W-1:0] credit;
  logic                pay_done;
  logic [15:0]         sales_total;

  modport master (
    output coin_valid, coin_type, sel, start, ldM, check, RC, canceled, done,
           coin_out_ready,
    input  in, error, coin_reject, vend, coin_out_valid, coin_out_type,
           credit, pay_done, sales_total
  );

  modport slave (
    input  coin_valid, coin_type, sel, start, ldM, check, RC, canceled, done,
           coin_out_ready,
    output in, error, coin_reject, vend, coin_out_valid, coin_out_type,
           credit, pay_done, sales_total
  );

endinterface

// File: rtl/vend_datapath_change_dispenser.sv
// Change/refund dispenser FSM: latches change one cycle after RC/canceled, then pays
// greedy coins; each coin is held on coin_out_* until the hopper raises ready.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rc,
  input  logic                canceled,
  input  logic [CREDIT_W-1:0] credit,
  input  logic [CREDIT_W-1:0] price,
  input  logic                coin_out_ready,
  output logic                vend,
  output logic                clr_credit,
  output logic                coin_out_valid,
  output logic [1:0]          coin_out_type,
  output logic                pay_done
);

  disp_state_t         state, state_nxt;
  logic [CREDIT_W-1:0] change, change_nxt;
  logic                vend_nxt;
  logic [1:0]          pick_type;
  logic [CREDIT_W-1:0] pick_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= D_IDLE;
      change <= '0;
      vend   <= 1'b0;
    end else begin
      state  <= state_nxt;
      change <= change_nxt;
      vend   <= vend_nxt;
    end
  end

  // Greedy pick depends only on the change register, so the offer is stable
  // for as long as the hopper stalls.
  always_comb begin
    pick_type = COIN_5C;
    pick_val  = CREDIT_W'(UNITS_5C);
    if (change >= CREDIT_W'(UNITS_25C)) begin
      pick_type = COIN_25C;
      pick_val  = CREDIT_W'(UNITS_25C);
    end else if (change >= CREDIT_W'(UNITS_10C)) begin
      pick_type = COIN_10C;
      pick_val  = CREDIT_W'(UNITS_10C);
    end
  end

  always_comb begin
    state_nxt      = state;
    change_nxt     = change;
    vend_nxt       = 1'b0;
    clr_credit     = 1'b0;
    coin_out_valid = 1'b0;
    coin_out_type  = COIN_5C;
    pay_done       = 1'b0;
    case (state)
      D_IDLE: begin
        if (rc) begin
          state_nxt  = D_LOAD;
          vend_nxt   = 1'b1;
          change_nxt = (credit >= price) ? (credit - price) : '0;
        end else if (canceled) begin
          state_nxt  = D_LOAD;
          change_nxt = credit;
        end
      end
      D_LOAD: begin
        clr_credit = 1'b1;
        state_nxt  = (change == '0) ? D_FIN : D_PAY;
      end
      D_PAY: begin
        coin_out_valid = 1'b1;
        coin_out_type  = pick_type;
        if (coin_out_ready) begin
          change_nxt = change - pick_val;
          if (change == pick_val) begin
            state_nxt = D_FIN;
          end
        end
      end
      D_FIN: begin
        pay_done = 1'b1;
      end
      default: begin
        state_nxt = D_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/vend_datapath.sv
// Vending datapath: credit accumulation, coin rejection, idle timer, change payout.
// Coin accept/reject lands 1 cycle after coin_valid; VEND_AUDIT_EN adds a sales counter.
module vend_datapath
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 40,
  parameter int IDLE_CYC   = 16
) (
  input logic           clk,
  input logic           reset,
  vend_datapath_if.slave bus
);

  localparam int IDLE_W = $clog2(IDLE_CYC + 1);

  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W:0]   sum;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                window;
  logic                coin_ok;
  logic                accept;
  logic                reject_q;
  logic                clr_credit;

  assign price  = CREDIT_W'(price_units(bus.sel));
  assign sum    = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_units(bus.coin_type));

  // Coins are only taken in the load states, and never while another
  // controller decode overlaps them or credit is being cleared.
  assign window = (bus.start | bus.ldM)
                & ~(bus.check | bus.RC | bus.canceled | bus.done)
                & ~clr_credit;
  assign coin_ok = window
                 && (bus.coin_type != COIN_BAD)
                 && (sum <= (CREDIT_W + 1)'(MAX_CREDIT));
  assign accept  = bus.coin_valid & coin_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q <= '0;
      reject_q <= 1'b0;
      idle_cnt <= '0;
    end else begin
      reject_q <= bus.coin_valid & ~coin_ok;
      if (clr_credit) begin
        credit_q <= '0;
      end else if (accept) begin
        credit_q <= sum[CREDIT_W-1:0];
      end
      if (accept) begin
        idle_cnt <= IDLE_W'(IDLE_CYC);
      end else if (idle_cnt != '0) begin
        idle_cnt <= idle_cnt - 1'b1;
      end
    end
  end

  assign bus.credit      = credit_q;
  assign bus.coin_reject = reject_q;
  assign bus.in          = (idle_cnt != '0);
  // Gated by reset so the combinational flag is low while the block is held.
  assign bus.error       = reset & bus.check & (credit_q < price);

  change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_disp (
    .clk            (clk),
    .reset          (reset),
    .rc             (bus.RC),
    .canceled       (bus.canceled),
    .credit         (credit_q),
    .price          (price),
    .coin_out_ready (bus.coin_out_ready),
    .vend           (bus.vend),
    .clr_credit     (clr_credit),
    .coin_out_valid (bus.coin_out_valid),
    .coin_out_type  (bus.coin_out_type),
    .pay_done       (bus.pay_done)
  );

`ifdef VEND_AUDIT_EN
  logic [15:0] sales_q;
  logic [16:0] audit_sum;

  assign audit_sum = {1'b0, sales_q} + 17'(price);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sales_q <= '0;
    end else if (bus.vend) begin
      sales_q <= audit_sum[16] ? 16'hFFFF : audit_sum[15:0];
    end
  end

  assign bus.sales_total = sales_q;
`else
  assign bus.sales_total = '0;
`endif

endmodule

// File: tb/tb_vend_datapath.sv
// Scoreboard bench for vend_datapath: directed coin/vend/refund scenarios push
// expected reject/vend/payout events; a negedge monitor pops and compares them.
module tb_vend_datapath;
  import vend_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vend_datapath_if #(.CREDIT_W(8)) bus ();

  vend_datapath #(
    .CREDIT_W   (8),
    .MAX_CREDIT (40),
    .IDLE_CYC   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int EV_REJ  = 0;
  localparam int EV_VEND = 4;
  localparam int EV_COIN = 8;   // plus coin type

`ifdef VEND_AUDIT_EN
  localparam int EXP_SALES = 7;
`else
  localparam int EXP_SALES = 0;
`endif

  int exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int code);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected actual=%0d expected=none", code);
    end else begin
      int e;
      e = exp_q.pop_front();
      chk("sb_event", code, e);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.coin_reject) sb_pop(EV_REJ);
      if (bus.vend) sb_pop(EV_VEND);
      if (bus.coin_out_valid && bus.coin_out_ready)
        sb_pop(EV_COIN + int'(bus.coin_out_type));
    end
  end

  task automatic idle_inputs();
    bus.coin_valid     = 1'b0;
    bus.coin_type      = 2'd0;
    bus.sel            = 2'd0;
    bus.start          = 1'b0;
    bus.ldM            = 1'b0;
    bus.check          = 1'b0;
    bus.RC             = 1'b0;
    bus.canceled       = 1'b0;
    bus.done           = 1'b0;
    bus.coin_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    repeat (2) @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic coin(input logic [1:0] t);
    @(posedge clk);
    #1;
    bus.coin_valid = 1'b1;
    bus.coin_type  = t;
    @(posedge clk);
    #1;
    bus.coin_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.pay_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.pay_done), 1);
  endtask

  task automatic wait_offer(input string name, input int budget);
    int n;
    n = 0;
    while (!bus.coin_out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.coin_out_valid), 1);
  endtask

  function automatic int out_bits();
    return int'({bus.in, bus.error, bus.coin_reject, bus.vend,
                 bus.coin_out_valid, bus.coin_out_type, bus.pay_done});
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    #12;
    chk("rst_outputs", out_bits(), 0);
    chk("rst_credit", int'(bus.credit), 0);
    chk("rst_sales", int'(bus.sales_total), 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Load 25c+10c+10c, idle timer, then a sel=2 vend with one 10c change.
    bus.ldM = 1'b1;
    coin(COIN_25C);
    coin(COIN_10C);
    coin(COIN_10C);
    chk("a_credit", int'(bus.credit), 9);
    repeat (15) @(posedge clk);
    #2 chk("a_in_last", int'(bus.in), 1);
    @(posedge clk);
    #2 chk("a_in_off", int'(bus.in), 0);
    bus.ldM   = 1'b0;
    bus.sel   = 2'd2;
    bus.check = 1'b1;
    #1 chk("a_error_sel2", int'(bus.error), 0);
    bus.sel = 2'd3;
    #1 chk("a_error_sel3", int'(bus.error), 1);
    bus.sel = 2'd2;
    @(posedge clk);
    #1;
    bus.check          = 1'b0;
    bus.RC             = 1'b1;
    bus.coin_out_ready = 1'b1;
    exp_q.push_back(EV_VEND);
    exp_q.push_back(EV_COIN + COIN_10C);
    repeat (2) @(posedge clk);
    #1 bus.RC = 1'b0;
    wait_done("a_pay_done", 20);
    chk("a_credit_clr", int'(bus.credit), 0);
    chk("a_sales", int'(bus.sales_total), EXP_SALES);

    // Credit 4, insufficient for sel=3, cancel refunds 10c+10c with a stalled hopper.
    do_reset();
    bus.ldM = 1'b1;
    coin(COIN_10C);
    coin(COIN_10C);
    chk("b_credit", int'(bus.credit), 4);
    bus.ldM   = 1'b0;
    bus.sel   = 2'd3;
    bus.check = 1'b1;
    #1 chk("b_error", int'(bus.error), 1);
    @(posedge clk);
    #1;
    bus.check          = 1'b0;
    bus.canceled       = 1'b1;
    bus.coin_out_ready = 1'b0;
    exp_q.push_back(EV_COIN + COIN_10C);
    exp_q.push_back(EV_COIN + COIN_10C);
    @(posedge clk);
    #1 bus.canceled = 1'b0;
    wait_offer("b_offer", 10);
    for (int i = 0; i < 5; i++) begin
      chk("b_stall_valid", int'(bus.coin_out_valid), 1);
      chk("b_stall_type", int'(bus.coin_out_type), COIN_10C);
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.coin_out_ready = 1'b1;
    wait_done("b_pay_done", 20);
    chk("b_credit_clr", int'(bus.credit), 0);

    // Ceiling and rejection cases.
    do_reset();
    bus.ldM = 1'b1;
    for (int i = 0; i < 7; i++) coin(COIN_25C);
    coin(COIN_10C);
    coin(COIN_5C);
    chk("c_credit38", int'(bus.credit), 38);
    exp_q.push_back(EV_REJ);
    coin(COIN_25C);
    chk("c_over_hold", int'(bus.credit), 38);
    exp_q.push_back(EV_REJ);
    coin(COIN_BAD);
    chk("c_bad_hold", int'(bus.credit), 38);
    coin(COIN_10C);
    chk("c_credit40", int'(bus.credit), 40);
    exp_q.push_back(EV_REJ);
    coin(COIN_5C);
    chk("c_over41", int'(bus.credit), 40);
    bus.check = 1'b1;
    exp_q.push_back(EV_REJ);
    coin(COIN_5C);
    chk("c_check_coin", int'(bus.credit), 40);
    bus.check = 1'b0;
    bus.ldM   = 1'b0;
    exp_q.push_back(EV_REJ);
    coin(COIN_5C);
    chk("c_no_window", int'(bus.credit), 40);

    // Reset in the middle of a stalled refund abandons the payout.
    do_reset();
    bus.ldM = 1'b1;
    coin(COIN_25C);
    coin(COIN_25C);
    chk("d_credit", int'(bus.credit), 10);
    bus.ldM            = 1'b0;
    bus.coin_out_ready = 1'b0;
    @(posedge clk);
    #1 bus.canceled = 1'b1;
    @(posedge clk);
    #1 bus.canceled = 1'b0;
    wait_offer("d_offer", 10);
    chk("d_type25", int'(bus.coin_out_type), COIN_25C);
    #2 reset = 1'b0;
    #1;
    chk("d_async_outputs", out_bits(), 0);
    chk("d_async_credit", int'(bus.credit), 0);
    bus.coin_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("d_no_payout", int'({bus.coin_out_valid, bus.pay_done}), 0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
